// File: rtl/instr_encoder.sv
// RV32I instruction assembler for the boot/test loader: encodes R/LD/S/SB requests
// into 32-bit words and streams them to instruction memory, ending with a self-loop.
module instr_encoder #(
    parameter int ADDR_W = 10,
    parameter int BASE   = 0,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_class,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [12:0]       imm,
    input  logic              seal,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] count,
    output logic              full,
    output logic              done,
    output logic              err_misalign
);

    localparam int          CW        = $clog2(DEPTH + 1);
    localparam logic [31:0] TERM_WORD = 32'h0000_0063;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_TERM = 2'd2, S_DONE = 2'd3} state_t;

    function automatic logic [31:0] encode(input logic [1:0] cls, input logic [4:0] f_rd,
                                           input logic [4:0] f_rs1, input logic [4:0] f_rs2,
                                           input logic [2:0] f3, input logic [6:0] f7,
                                           input logic [12:0] im);
        logic [31:0] w;
        case (cls)
            2'b00:   w = {f7, f_rs2, f_rs1, f3, f_rd, 7'b0110011};
            2'b01:   w = {im[11:0], f_rs1, f3, f_rd, 7'b0000011};
            2'b10:   w = {im[11:5], f_rs2, f_rs1, f3, im[4:0], 7'b0100011};
            2'b11:   w = {im[12], im[10:5], f_rs2, f_rs1, f3, im[4:1], im[11], 7'b1100011};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    state_t              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [31:0]         out_data_q, out_data_d;
    logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [CW-1:0]       loaded_q, loaded_d;
    logic                full_q, full_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                seal_pend_q, seal_pend_d;

    logic out_free_s, out_hs_s, seal_req_s;
    logic req_ready_s, req_fire_s, seal_fire_s, start_fire_s;

    assign out_free_s = !out_valid_q || out_ready;
    assign out_hs_s   = out_valid_q && out_ready;
    // A seal pulse that arrives while the output is stalled is remembered until it can fire.
    assign seal_req_s = seal || seal_pend_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_fire_s) state_d = S_RUN;  else state_d = S_IDLE;
            S_RUN:   if (seal_fire_s)  state_d = S_TERM; else state_d = S_RUN;
            S_TERM:  if (out_hs_s)     state_d = S_DONE; else state_d = S_TERM;
            S_DONE:  if (start_fire_s) state_d = S_RUN;  else state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: handshake and load strobes; seal outranks a simultaneous request.
    always_comb begin
        start_fire_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        seal_fire_s  = (state_q == S_RUN) && seal_req_s && out_free_s;
        req_ready_s  = (state_q == S_RUN) && !full_q && out_free_s && !seal_req_s;
        req_fire_s   = req_valid && req_ready_s;
    end

    // Datapath next-state: output register, address, counters and sticky flags.
    always_comb begin
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        next_addr_d = next_addr_q;
        count_d     = count_q;
        loaded_d    = loaded_q;
        full_d      = full_q;
        done_d      = done_q;
        err_d       = err_q;
        seal_pend_d = seal_pend_q;
        if (start_fire_s) begin
            next_addr_d = ADDR_W'(BASE);
            count_d     = {ADDR_W{1'b0}};
            loaded_d    = {CW{1'b0}};
            full_d      = 1'b0;
            done_d      = 1'b0;
            err_d       = 1'b0;
            seal_pend_d = 1'b0;
        end else begin
            if (out_hs_s) begin
                count_d     = count_q + ADDR_W'(1);
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
            if (req_fire_s || seal_fire_s) begin
                out_valid_d = 1'b1;
                out_addr_d  = next_addr_q;
                next_addr_d = next_addr_q + ADDR_W'(4);
                out_data_d  = seal_fire_s ? TERM_WORD
                                          : encode(req_class, rd, rs1, rs2, funct3, funct7, imm);
            end else begin
                out_data_d  = out_data_q;
            end
            if (req_fire_s) begin
                loaded_d = loaded_q + CW'(1);
                if (loaded_q == CW'(DEPTH - 2)) full_d = 1'b1; else full_d = full_q;
                if ((req_class == 2'b11) && imm[0]) err_d = 1'b1; else err_d = err_q;
            end else begin
                loaded_d = loaded_q;
            end
            if (seal_fire_s) begin
                seal_pend_d = 1'b0;
            end else if ((state_q == S_RUN) && seal) begin
                seal_pend_d = 1'b1;
            end else begin
                seal_pend_d = seal_pend_q;
            end
            if ((state_q == S_TERM) && out_hs_s) done_d = 1'b1; else done_d = done_q;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= {ADDR_W{1'b0}};
            out_data_q  <= 32'h0000_0000;
            next_addr_q <= ADDR_W'(BASE);
            count_q     <= {ADDR_W{1'b0}};
            loaded_q    <= {CW{1'b0}};
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            seal_pend_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            next_addr_q <= next_addr_d;
            count_q     <= count_d;
            loaded_q    <= loaded_d;
            full_q      <= full_d;
            done_q      <= done_d;
            err_q       <= err_d;
            seal_pend_q <= seal_pend_d;
        end
    end

    assign req_ready    = req_ready_s;
    assign out_valid    = out_valid_q;
    assign out_addr     = out_addr_q;
    assign out_data     = out_data_q;
    assign count        = count_q;
    assign full         = full_q;
    assign done         = done_q;
    assign err_misalign = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: table of hand-encoded instructions streamed through a
// scoreboard, plus hand-written backpressure, seal-priority and reset sequences.
module tb_instr_encoder;

    localparam int ADDR_W = 10;
    localparam int BASE   = 16;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n, start, req_valid, req_ready, seal, out_valid, out_ready;
    logic [1:0]        req_class;
    logic [4:0]        rd, rs1, rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [12:0]       imm;
    logic [ADDR_W-1:0] out_addr, count;
    logic [31:0]       out_data;
    logic              full, done, err_misalign;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .req_valid(req_valid), .req_ready(req_ready),
        .req_class(req_class), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .seal(seal), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .count(count), .full(full), .done(done),
        .err_misalign(err_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cls;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [12:0] imm;
        logic [31:0] exp_word;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } exp_t;

    vec_t              tbl [9];
    exp_t              sb_q [$];
    logic [ADDR_W-1:0] exp_addr;
    int                n_vec = 0;
    int                n_fail = 0;

    function automatic vec_t mk(logic [1:0] c, logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                                logic [2:0] f3, logic [6:0] f7, logic [12:0] im,
                                logic [31:0] w, logic e);
        vec_t v;
        v.cls = c; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.f3 = f3; v.f7 = f7; v.imm = im;
        v.exp_word = w; v.exp_err = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every output handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_word", 64'(out_data), 64'hDEAD);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_addr", 64'(out_addr), 64'(e.addr));
                check("out_data", 64'(out_data), 64'(e.data));
            end
        end
    end

    task automatic push_exp(input logic [31:0] w);
        exp_t e;
        e.addr = exp_addr;
        e.data = w;
        sb_q.push_back(e);
        exp_addr = exp_addr + ADDR_W'(4);
    endtask

    task automatic drive(input vec_t v);
        req_class = v.cls; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; funct7 = v.f7; imm = v.imm;
    endtask

    // Entered and left at posedge+1; leaves req_valid high for back-to-back use.
    task automatic send(input vec_t v);
        bit ok = 1'b0;
        drive(v);
        req_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready) begin
                push_exp(v.exp_word);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("req_accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = ADDR_W'(BASE);
        check("start_count", 64'(count), 64'd0);
        check("start_done", 64'(done), 64'd0);
        check("start_err", 64'(err_misalign), 64'd0);
    endtask

    task automatic do_seal();
        bit ok = 1'b0;
        seal = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!out_valid || out_ready) begin
                push_exp(32'h0000_0063);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("seal_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        seal = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input logic [ADDR_W-1:0] exp_count);
        bit ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", 64'(ok), 64'd1);
        check("done_count", 64'(count), 64'(exp_count));
        check("done_req_ready", 64'(req_ready), 64'd0);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = mk(2'b00, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 13'h1ABC, 32'h0020_81B3, 1'b0);
        tbl[1] = mk(2'b01, 5'd5,  5'd2,  5'd17, 3'd2, 7'h55, 13'h0008, 32'h0081_2283, 1'b0);
        tbl[2] = mk(2'b10, 5'd9,  5'd2,  5'd5,  3'd2, 7'h7F, 13'h000C, 32'h0051_2623, 1'b0);
        tbl[3] = mk(2'b11, 5'd7,  5'd1,  5'd2,  3'd0, 7'h11, 13'h1FF8, 32'hFE20_8CE3, 1'b0);
        tbl[4] = mk(2'b11, 5'd7,  5'd1,  5'd2,  3'd0, 7'h11, 13'h1FF9, 32'hFE20_8CE3, 1'b1);
        tbl[5] = mk(2'b00, 5'd10, 5'd11, 5'd12, 3'd0, 7'h20, 13'h1FFF, 32'h40C5_8533, 1'b1);
        tbl[6] = mk(2'b01, 5'd1,  5'd0,  5'd31, 3'd0, 7'h7F, 13'h1FFF, 32'hFFF0_0083, 1'b0);
        tbl[7] = mk(2'b10, 5'd0,  5'd31, 5'd31, 3'd0, 7'h00, 13'h1800, 32'h81FF_8023, 1'b0);
        tbl[8] = mk(2'b11, 5'd31, 5'd3,  5'd4,  3'd1, 7'h00, 13'h0FFE, 32'h7E41_9FE3, 1'b0);

        rst_n = 1'b0; start = 1'b0; req_valid = 1'b0; seal = 1'b0; out_ready = 1'b1;
        drive(tbl[0]);
        exp_addr = ADDR_W'(BASE);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_flags", 64'({full, done, err_misalign}), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        @(posedge clk); #1;

        // Three programs of three words each; DEPTH-1 data words fills the program.
        for (int p = 0; p < 3; p++) begin
            do_start();
            out_ready = (p != 2);
            for (int k = 0; k < 3; k++) begin
                send(tbl[3*p + k]);
                if (p == 0 && k == 0) check("latency_out_valid", 64'(out_valid), 64'd1);
                if (p == 1) check("err_misalign", 64'(err_misalign), 64'(tbl[3*p + k].exp_err));
                if (p == 2 && k == 0) begin
                    drive(tbl[7]);
                    for (int c = 0; c < 3; c++) begin
                        @(negedge clk);
                        check("bp_req_ready", 64'(req_ready), 64'd0);
                        check("bp_out_data", 64'(out_data), 64'h0000_0000_FFF0_0083);
                        check("bp_out_addr", 64'(out_addr), 64'(BASE));
                        check("bp_count", 64'(count), 64'd0);
                    end
                    @(posedge clk); #1;
                    out_ready = 1'b1;
                end
            end
            drive(tbl[0]);
            repeat (2) begin
                @(negedge clk);
                check("full", 64'(full), 64'd1);
                check("full_stall", 64'(req_ready), 64'd0);
            end
            @(posedge clk); #1;
            do_seal();
            wait_done(ADDR_W'(4));
        end

        // Seal and a request in the same cycle: the seal wins.
        do_start();
        send(tbl[1]);
        drive(tbl[2]);
        seal = 1'b1;
        @(negedge clk);
        check("seal_prio_ready", 64'(req_ready), 64'd0);
        push_exp(32'h0000_0063);
        @(posedge clk); #1;
        seal = 1'b0;
        @(negedge clk);
        check("term_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_done(ADDR_W'(2));

        // Reset while a word is stalled in the output register.
        do_start();
        out_ready = 1'b0;
        send(tbl[5]);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_req_ready", 64'(req_ready), 64'd0);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_req_ready", 64'(req_ready), 64'd0);
            check("idle_out_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        do_start();
        send(tbl[8]);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_count", 64'(count), 64'd1);
        check("post_rst_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
